// File: rtl/smm_csr_pack.sv
// CSR packer: gathers (row,col,val) triplets of a 32x32 product, counting-sorts
// them by row and streams 33 row pointers followed by the column/value pairs.
module smm_csr_pack #(
  parameter int MAX_NNZ = 46,
  parameter int DIM     = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [4:0] in_row,
  input  logic [4:0] in_col,
  input  logic [8:0] in_val,
  input  logic       in_done,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_kind,
  output logic [5:0] out_ptr,
  output logic [4:0] out_col,
  output logic [8:0] out_val,
  output logic       err_ovf
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SCAN, S_SCATTER, S_OUT} state_e;
  typedef struct packed { logic [4:0] row; logic [4:0] col; logic [8:0] val; } trip_t;
  typedef struct packed { logic [4:0] col; logic [8:0] val; } ent_t;

  state_e     state_q, state_d;
  logic [5:0] n_q, n_d;
  logic [6:0] k_q, k_d;
  logic       err_q, err_d;
  logic       ov_q, ov_d;
  logic       kind_q, kind_d;
  logic [5:0] optr_q, optr_d;
  logic [4:0] ocol_q, ocol_d;
  logic [8:0] oval_q, oval_d;

  trip_t      buf_mem [MAX_NNZ];
  ent_t       csr_mem [MAX_NNZ];
  logic [5:0] cnt_q   [DIM];
  logic [5:0] ptr_q   [DIM+1];
  logic [5:0] fill_q  [DIM];

  logic       accept, store, scan_en, scat_en, clr_rows;
  trip_t      scat_t;
  ent_t       beat_e;
  logic [6:0] last_k;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept   = in_ready && in_valid && (in_val != 9'd0);
  assign store    = accept && (n_q != 6'(MAX_NNZ));
  assign scat_t   = buf_mem[k_q[5:0]];
  assign beat_e   = csr_mem[6'(k_q - 7'(DIM + 1))];
  // k_q doubles as scan row, scatter index and beat index; last_k is the final beat.
  assign last_k   = 7'(DIM) + {1'b0, n_q};

  always_comb begin
    // NOTE: every next-state value is defaulted first so no branch can leave one unassigned and infer a latch.
    state_d  = state_q;
    n_d      = n_q;
    k_d      = k_q;
    err_d    = err_q;
    ov_d     = ov_q;
    kind_d   = kind_q;
    optr_d   = optr_q;
    ocol_d   = ocol_q;
    oval_d   = oval_q;
    scan_en  = 1'b0;
    scat_en  = 1'b0;
    clr_rows = 1'b0;
    if (store) n_d = n_q + 6'd1;

    unique case (state_q)
      S_IDLE: begin
        if (in_done || accept) begin
          err_d   = 1'b0;
          k_d     = 7'd0;
          state_d = in_done ? S_SCAN : S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept && !store) err_d = 1'b1;
        if (in_done) begin
          k_d     = 7'd0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        scan_en = 1'b1;
        k_d     = k_q + 7'd1;
        if (k_q == 7'(DIM - 1)) begin
          k_d     = 7'd0;
          state_d = (n_q == 6'd0) ? S_OUT : S_SCATTER;
        end
      end
      S_SCATTER: begin
        scat_en = 1'b1;
        k_d     = k_q + 7'd1;
        if (k_q == {1'b0, n_q} - 7'd1) begin
          k_d     = 7'd0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (!ov_q || out_ready) begin
          if (k_q <= last_k) begin
            ov_d = 1'b1;
            k_d  = k_q + 7'd1;
            if (k_q <= 7'(DIM)) begin
              kind_d = 1'b0;
              optr_d = ptr_q[k_q[5:0]];
              ocol_d = 5'd0;
              oval_d = 9'd0;
            end else begin
              kind_d = 1'b1;
              optr_d = 6'd0;
              ocol_d = beat_e.col;
              oval_d = beat_e.val;
            end
          end else begin
            ov_d     = 1'b0;
            kind_d   = 1'b0;
            optr_d   = 6'd0;
            ocol_d   = 5'd0;
            oval_d   = 9'd0;
            k_d      = 7'd0;
            n_d      = 6'd0;
            clr_rows = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values, so ptr[r+1] sees the ptr[r] of the previous cycle.
    if (rst_n) begin
      state_q <= S_IDLE;
      n_q     <= 6'd0;
      k_q     <= 7'd0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
      kind_q  <= 1'b0;
      optr_q  <= 6'd0;
      ocol_q  <= 5'd0;
      oval_q  <= 9'd0;
      for (int r = 0; r < DIM; r++) begin
        cnt_q[r]  <= 6'd0;
        fill_q[r] <= 6'd0;
      end
      for (int r = 0; r <= DIM; r++) ptr_q[r] <= 6'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      err_q   <= err_d;
      ov_q    <= ov_d;
      kind_q  <= kind_d;
      optr_q  <= optr_d;
      ocol_q  <= ocol_d;
      oval_q  <= oval_d;
      if (clr_rows) begin
        for (int r = 0; r < DIM; r++) begin
          cnt_q[r]  <= 6'd0;
          fill_q[r] <= 6'd0;
        end
        for (int r = 0; r <= DIM; r++) ptr_q[r] <= 6'd0;
      end
      if (store) cnt_q[in_row] <= cnt_q[in_row] + 6'd1;
      if (scan_en) begin
        ptr_q[k_q[5:0] + 6'd1] <= ptr_q[k_q[5:0]] + cnt_q[k_q[4:0]];
        fill_q[k_q[4:0]]       <= ptr_q[k_q[5:0]];
      end
      if (scat_en) fill_q[scat_t.row] <= fill_q[scat_t.row] + 6'd1;
    end
  end

  // NOTE: the entry and CSR memories carry no reset; every slot read is written earlier in the same matrix.
  always_ff @(posedge clk) begin
    if (store)   buf_mem[n_q] <= {in_row, in_col, in_val};
    if (scat_en) csr_mem[fill_q[scat_t.row]] <= {scat_t.col, scat_t.val};
  end

  assign out_valid = ov_q;
  assign out_kind  = kind_q;
  assign out_ptr   = optr_q;
  assign out_col   = ocol_q;
  assign out_val   = oval_q;
  assign err_ovf   = err_q;

endmodule

// File: tb/tb_smm_csr_pack.sv
// Scoreboard bench for smm_csr_pack: a list-level CSR model queues expected
// beats, an independent monitor pops and compares on each transfer.
module tb_smm_csr_pack;

  localparam int MAXN = 46;

  typedef struct packed { logic [4:0] row; logic [4:0] col; logic [8:0] val; } trip_t;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, in_done, in_ready;
  logic [4:0] in_row, in_col;
  logic [8:0] in_val;
  logic       out_valid, out_ready, out_kind, err_ovf;
  logic [5:0] out_ptr;
  logic [4:0] out_col;
  logic [8:0] out_val;

  smm_csr_pack dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_row(in_row), .in_col(in_col), .in_val(in_val),
    .in_done(in_done), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_ptr(out_ptr), .out_col(out_col), .out_val(out_val), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0, cyc = 0;
  int          exp_first = -1;
  int          rmode = 0;
  bit          mon_en = 1'b0;
  bit          exp_ovf = 1'b0;
  trip_t       stim_q[$];
  logic [20:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add(input int r, input int c, input int v);
    stim_q.push_back({5'(r), 5'(c), 9'(v)});
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_kind"},  out_kind,  0);
    check({tag, "_out_ptr"},   out_ptr,   0);
    check({tag, "_out_col"},   out_col,   0);
    check({tag, "_out_val"},   out_val,   0);
    check({tag, "_err_ovf"},   err_ovf,   0);
    check({tag, "_in_ready"},  in_ready,  1);
  endtask

  // Downstream ready: always 1, the 1,0,0,1 pattern, or random.
  initial begin
    int         ph = 0;
    logic [3:0] pat = 4'b1001;
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rmode)
        1: begin out_ready = pat[3 - ph]; ph = (ph + 1) % 4; end
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer, checks stall stability,
  // zero fields while idle and the first-beat latency.
  initial begin
    bit          prev_v = 1'b0, stall = 1'b0;
    logic [20:0] held = '0, got;
    forever begin
      @(negedge clk);
      got = {out_kind, out_ptr, out_col, out_val};
      if (!mon_en) begin
        prev_v = 1'b0;
        stall  = 1'b0;
      end else begin
        if (stall) check("stall_hold", {out_valid, got}, {1'b1, held});
        if (out_valid && !prev_v && exp_first >= 0) begin
          check("latency", cyc, exp_first);
          exp_first = -1;
        end
        if (!out_valid) check("idle_zero", got, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL extra_beat: got %0h expected no beat (cycle %0d)", got, cyc);
          end else begin
            check("beat", got, exp_q.pop_front());
          end
        end
        stall  = out_valid && !out_ready;
        held   = got;
        prev_v = out_valid;
      end
    end
  end

  // Model: keep the first MAXN nonzero triplets; ptr[r] counts kept entries
  // with row < r; entries follow grouped by row, arrival order within a row.
  task automatic send(input bit done_last);
    trip_t kept[$];
    int    nz = 0;
    int    p, n;
    foreach (stim_q[i]) begin
      if (stim_q[i].val != 9'd0) begin
        nz++;
        if (kept.size() < MAXN) kept.push_back(stim_q[i]);
      end
    end
    exp_ovf = (nz > MAXN);
    n = kept.size();
    for (int r = 0; r <= 32; r++) begin
      p = 0;
      foreach (kept[j]) if (int'(kept[j].row) < r) p++;
      exp_q.push_back({1'b0, 6'(p), 5'd0, 9'd0});
    end
    for (int r = 0; r < 32; r++)
      foreach (kept[j])
        if (int'(kept[j].row) == r) exp_q.push_back({1'b1, 6'd0, kept[j].col, kept[j].val});

    foreach (stim_q[i]) begin
      in_valid = 1'b1;
      in_row   = stim_q[i].row;
      in_col   = stim_q[i].col;
      in_val   = stim_q[i].val;
      in_done  = done_last && (i == stim_q.size() - 1);
      if (in_done) exp_first = cyc + 34 + n;
      @(posedge clk); #1;
    end
    if (!done_last || stim_q.size() == 0) begin
      in_valid  = 1'b0;
      in_done   = 1'b1;
      exp_first = cyc + 34 + n;
      @(posedge clk); #1;
    end
    // Input activity while sorting must be ignored.
    repeat (20) begin
      in_valid = 1'b1;
      in_row   = 5'($urandom);
      in_col   = 5'($urandom);
      in_val   = 9'($urandom_range(1, 511));
      in_done  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_done  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: %0d beats outstanding, expected 0", tag, exp_q.size());
      exp_q.delete();
    end
    check({tag, "_err_ovf"}, err_ovf, exp_ovf);
    check({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    in_done  = 1'b0;
    in_row   = '0;
    in_col   = '0;
    in_val   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    check_quiet("reset");
    mon_en = 1'b1;

    stim_q.delete();
    send(1'b0);
    wait_done("empty");

    stim_q.delete();
    add(5, 3, 7); add(1, 0, 2); add(5, 1, 9);
    send(1'b0);
    wait_done("basic");

    rmode = 1;
    send(1'b1);
    wait_done("stall");
    rmode = 0;

    stim_q.delete();
    for (int c = 0; c < 32; c++) add(31, c, c + 1);
    for (int c = 0; c < 16; c++) add(0, c, c + 100);
    send(1'b0);
    wait_done("ovf");

    stim_q.delete();
    add(4, 4, 0); add(2, 2, 255);
    send(1'b1);
    wait_done("zero_val");

    rmode = 2;
    repeat (6) begin
      int n = $urandom_range(0, 50);
      stim_q.delete();
      for (int i = 0; i < n; i++)
        add($urandom_range(0, 31), $urandom_range(0, 31),
            ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 511));
      send(1'($urandom_range(0, 1)));
      wait_done("random");
    end
    rmode = 0;

    stim_q.delete();
    add(5, 3, 7); add(1, 0, 2); add(5, 1, 9);
    send(1'b0);
    t = 0;
    while (!out_valid && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    check("rst_mid_reached_out", t < 200, 1);
    repeat (4) begin @(posedge clk); #1; end
    mon_en = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    check_quiet("rst_mid");
    exp_q.delete();
    exp_first = -1;
    mon_en    = 1'b1;

    stim_q.delete();
    add(7, 9, 300);
    send(1'b1);
    wait_done("after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/smm_csr_pack.md
Name: smm_csr_pack

Overview:
Downstream stage of the sparse matrix multiplier. It collects the nonzero result triplets (row, col, val) of one 32x32 product in any order. It converts them to CSR form by counting sort, then streams the 33 row pointers followed by the column/value pairs over a valid/ready interface to the result-writeback stage.

Parameters:
MAX_NNZ, 46, entry buffer depth; entries beyond this are dropped and flagged.
DIM, 32, matrix dimension (rows/cols); index width is 5 bits.

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  reset, synchronous, active-high (asserted = 1)
in_valid  input  1  triplet valid
in_row  input  5  triplet row
in_col  input  5  triplet column
in_val  input  9  triplet value
in_done  input  1  one-cycle pulse: end of matrix (may coincide with the last in_valid)
in_ready  output  1  1 in IDLE/LOAD, 0 otherwise
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts beat
out_kind  output  1  0 = row pointer beat, 1 = entry beat
out_ptr  output  6  row pointer value (kind 0)
out_col  output  5  column (kind 1)
out_val  output  9  value (kind 1)
err_ovf  output  1  sticky: an entry was dropped because the buffer was full

Behaviour:
- Reset (rst_n=1 at an edge): state IDLE. All counters, per-row counts and pointers are cleared. out_valid=0, out_kind=0, out_ptr=0, out_col=0, out_val=0, err_ovf=0, in_ready=1. Reset mid-operation aborts immediately with the same result.
- States: IDLE, LOAD, SCAN, SCATTER, OUT.
- IDLE: in_valid=1 stores the entry and moves to LOAD. in_done=1 moves to SCAN with or without an entry, so the empty matrix is legal. A write with in_val==0 is ignored.
- LOAD: each accepted in_valid with in_val!=0 is appended to buf[n], cnt[in_row] is incremented, and n is incremented.
- LOAD overflow: if n==MAX_NNZ the entry is dropped and err_ovf is set. err_ovf clears only on reset or on the next IDLE->LOAD/SCAN transition.
- Leaving LOAD: in_done=1 moves to SCAN. An in_valid in the same cycle is stored first.
- Duplicate (row,col) entries are stored as separate entries; no merging.
- Outside IDLE/LOAD: in_ready=0, and in_valid and in_done are ignored.
- SCAN: exactly 32 cycles, r=0..31, with ptr[0]=0 and ptr[r+1]=ptr[r]+cnt[r]. fill[r] is initialised to ptr[r].
- SCATTER: exactly n cycles, one per entry in buffer order i=0..n-1: csr[fill[row_i]] <= {col_i,val_i}, then fill[row_i]++. This keeps the sort stable: entries within a row keep arrival order. n=0 skips straight to OUT.
- OUT: beats 0..32 carry out_kind=0, out_ptr=ptr[k]. Beats 33..32+n carry out_kind=1, out_col/out_val=csr[k-33], with out_ptr=0.
- Latency: out_valid first rises at edge e0+33+n, where e0 is the edge sampling in_done.
- Handshake: a beat transfers on a cycle with out_valid&out_ready. While out_ready=0, out_valid and all out_* fields hold stable.
- After the last beat transfers, out_valid falls on the next edge and the state returns to IDLE with n, cnt, fill and ptr cleared. out_valid has no bubble between beats when out_ready stays 1.
- Unused output fields are driven 0: out_col/out_val on kind 0 beats, out_ptr on kind 1 beats, and all fields when out_valid=0.
- Widths: cnt 6 bits, ptr 6 bits (max 46), val passes through unchanged.

Test Plan:
- Reset mid-OUT with out_ready=1 -> next cycle out_valid=0, all outputs 0, in_ready=1. A new single-entry matrix then completes normally.
- Empty matrix: in_done alone -> after 33 cycles, 33 beats of kind 0 all with out_ptr=0, no entry beats, back to IDLE.
- Entries (5,3,7), (1,0,2), (5,1,9) then in_done -> ptr[0..1]=0, ptr[2..5]=1, ptr[6..32]=3. Entry beats in order: (0,2), (3,7), (1,9).
- Same stimulus with out_ready toggling 1,0,0,1 repeatedly -> identical beat sequence, fields stable while stalled, 36 transfers total.
- 48 nonzero entries (row 31, col 0..31, then row 0, col 0..15) -> err_ovf=1, ptr[32]=46. The first 46 entries are kept: ptr[1..31]=14, row 31 holds cols 0..31, row 0 holds cols 0..13.
- Triplet with in_val=0 plus (2,2,255) with in_done in the same cycle -> zero entry ignored, ptr[3..32]=1, one entry beat (2,255).
